// File: rtl/mem_wb_regfile.sv
// mem_wb_regfile: write-back boundary of the 5-stage pipeline.
//   The mem-stage result is latched into the wb entry at a clock edge and
//   committed into a 32 x 32 register file on the following edge. Two
//   combinational read ports serve decode, bypassing the pending wb entry.
//   A committed-write counter is kept for bring-up and performance checks.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_des_addr/exist/data        result arriving from the mem stage
//   stall_mem, stall_wb, flush     pipeline control for the wb latch
//   re1/raddr1/rdata1              read port 1 (combinational)
//   re2/raddr2/rdata2              read port 2 (combinational)
//   wb_des_addr/exist/data         latched wb entry (forwarding to decode)
//   wb_write_cnt                   count of committed register writes
module mem_wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_des_addr,
    input  logic              mem_des_exist,
    input  logic [DATA_W-1:0] mem_des_data,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_des_addr,
    output logic              wb_des_exist,
    output logic [DATA_W-1:0] wb_des_data,
    output logic [31:0]       wb_write_cnt
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [ADDR_W-1:0] wb_addr_p0;
    logic              vld_p0;
    logic [DATA_W-1:0] wb_data_p0;
    logic [31:0]       write_cnt;

    logic              commit_en;
    logic [DATA_W-1:0] reg_rd1;
    logic [DATA_W-1:0] reg_rd2;

    // Read-port select: reset, disabled port and reg 0 read as zero; the
    // pending wb entry takes precedence over the (stale) array contents.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic              rst_i,
        input logic              re,
        input logic [ADDR_W-1:0] addr,
        input logic              byp_vld,
        input logic [ADDR_W-1:0] byp_addr,
        input logic [DATA_W-1:0] byp_data,
        input logic [DATA_W-1:0] arr_data
    );
        if (rst_i || !re || addr == '0)
            return '0;
        if (byp_vld && addr == byp_addr)
            return byp_data;
        return arr_data;
    endfunction

    assign commit_en = vld_p0 && (wb_addr_p0 != '0);

    // ---- mem -> wb latch (p0) and wb -> register file commit ----
    // The commit uses the pre-edge wb entry, so it happens regardless of the
    // flush/stall that decides what the entry becomes at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_addr_p0 <= '0;
            vld_p0     <= 1'b0;
            wb_data_p0 <= '0;
            write_cnt  <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            if (commit_en) begin
                regs[wb_addr_p0] <= wb_data_p0;
                write_cnt        <= write_cnt + 32'd1;
            end

            if (flush || (stall_mem && !stall_wb)) begin
                wb_addr_p0 <= '0;
                vld_p0     <= 1'b0;
                wb_data_p0 <= '0;
            end else if (!stall_mem) begin
                wb_addr_p0 <= mem_des_addr;
                vld_p0     <= mem_des_exist;
                wb_data_p0 <= mem_des_data;
            end
        end
    end

    // ---- decode read ports (combinational) ----
    assign reg_rd1 = regs[raddr1];
    assign reg_rd2 = regs[raddr2];

    always_comb begin
        rdata1 = read_sel(rst, re1, raddr1, vld_p0, wb_addr_p0, wb_data_p0, reg_rd1);
        rdata2 = read_sel(rst, re2, raddr2, vld_p0, wb_addr_p0, wb_data_p0, reg_rd2);
    end

    assign wb_des_addr  = wb_addr_p0;
    assign wb_des_exist = vld_p0;
    assign wb_des_data  = wb_data_p0;
    assign wb_write_cnt = write_cnt;

endmodule

// File: tb/tb_mem_wb_regfile.sv
// tb_mem_wb_regfile: directed-vector bench for mem_wb_regfile.
module tb_mem_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_des_addr;
    logic        mem_des_exist;
    logic [31:0] mem_des_data;
    logic        stall_mem, stall_wb, flush;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic [4:0]  wb_des_addr;
    logic        wb_des_exist;
    logic [31:0] wb_des_data;
    logic [31:0] wb_write_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .mem_des_addr (mem_des_addr),
        .mem_des_exist(mem_des_exist),
        .mem_des_data (mem_des_data),
        .stall_mem    (stall_mem),
        .stall_wb     (stall_wb),
        .flush        (flush),
        .re1          (re1),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .re2          (re2),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .wb_des_addr  (wb_des_addr),
        .wb_des_exist (wb_des_exist),
        .wb_des_data  (wb_des_data),
        .wb_write_cnt (wb_write_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic [4:0] a, input logic e, input logic [31:0] d);
        mem_des_addr  = a;
        mem_des_exist = e;
        mem_des_data  = d;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        re1 = 1'b1; re2 = 1'b1;
        raddr1 = a1; raddr2 = a2;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem(5'd0, 1'b0, 32'h0);
        stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
        re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
        step();

        // 1. reset after preloading reg 3
        rst = 1'b0;
        mem(5'd3, 1'b1, 32'h0000_A5A5);
        step();
        mem(5'd0, 1'b0, 32'h0);
        step();
        rd(5'd3, 5'd3);
        check("preload_rd1", rdata1, 32'h0000_A5A5);
        check("preload_cnt", wb_write_cnt, 32'd1);
        mem(5'd4, 1'b1, 32'h4444);
        step();
        rst = 1'b1;
        #1;
        check("rst_comb_rd", rdata1, 32'h0);
        step();
        check("rst_rd1", rdata1, 32'h0);
        check("rst_wb_addr", {27'b0, wb_des_addr}, 32'h0);
        check("rst_wb_exist", {31'b0, wb_des_exist}, 32'h0);
        check("rst_wb_data", wb_des_data, 32'h0);
        check("rst_cnt", wb_write_cnt, 32'h0);
        rst = 1'b0;
        mem(5'd0, 1'b0, 32'h0);
        #1;
        check("post_rst_reg3", rdata1, 32'h0);
        rd(5'd4, 5'd4);
        check("post_rst_reg4", rdata2, 32'h0);

        // 2. basic write with bypass then commit
        mem(5'd5, 1'b1, 32'hDEAD_BEEF);
        step();
        mem(5'd0, 1'b0, 32'h0);
        rd(5'd5, 5'd5);
        check("wr_wb_data", wb_des_data, 32'hDEAD_BEEF);
        check("wr_bypass", rdata1, 32'hDEAD_BEEF);
        check("wr_cnt0", wb_write_cnt, 32'd0);
        step();
        check("wr_reg5_p1", rdata1, 32'hDEAD_BEEF);
        check("wr_reg5_p2", rdata2, 32'hDEAD_BEEF);
        check("wr_cnt1", wb_write_cnt, 32'd1);
        re1 = 1'b0; #1;
        check("re1_off", rdata1, 32'h0);

        // 3. writes to reg 0 are dropped
        mem(5'd0, 1'b1, 32'h1234);
        rd(5'd0, 5'd0);
        step();
        check("r0_bypass", rdata1, 32'h0);
        check("r0_wb_exist", {31'b0, wb_des_exist}, 32'h1);
        mem(5'd0, 1'b0, 32'h0);
        step();
        check("r0_rd", rdata1, 32'h0);
        check("r0_cnt", wb_write_cnt, 32'd1);

        // 4. stalls
        mem(5'd9, 1'b1, 32'h99);
        step();
        stall_mem = 1'b1; stall_wb = 1'b0;
        step();
        check("stall_bubble", {31'b0, wb_des_exist}, 32'h0);
        check("stall_cnt", wb_write_cnt, 32'd2);
        stall_mem = 1'b0;
        mem(5'd10, 1'b1, 32'h10);
        step();
        stall_mem = 1'b1; stall_wb = 1'b1;
        mem(5'd11, 1'b1, 32'h11);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_addr", {27'b0, wb_des_addr}, 32'd10);
            check("hold_data", wb_des_data, 32'h10);
            check("hold_cnt", wb_write_cnt, 32'd3 + i);
        end
        stall_mem = 1'b0; stall_wb = 1'b0;
        mem(5'd0, 1'b0, 32'h0);
        step();
        rd(5'd10, 5'd11);
        check("hold_cnt_end", wb_write_cnt, 32'd6);
        check("hold_reg10", rdata1, 32'h10);
        check("hold_reg11", rdata2, 32'h0);

        // 5. flush wins over a loading stage
        mem(5'd12, 1'b1, 32'h12);
        step();
        flush = 1'b1;
        mem(5'd7, 1'b1, 32'h55);
        step();
        check("flush_bubble", {31'b0, wb_des_exist}, 32'h0);
        check("flush_commit_cnt", wb_write_cnt, 32'd7);
        flush = 1'b0;
        mem(5'd0, 1'b0, 32'h0);
        step();
        rd(5'd7, 5'd12);
        check("flush_reg7", rdata1, 32'h0);
        check("flush_reg12", rdata2, 32'h12);
        check("flush_cnt", wb_write_cnt, 32'd7);

        // bypass overrides stale array contents
        mem(5'd12, 1'b1, 32'h5555);
        step();
        mem(5'd0, 1'b0, 32'h0);
        rd(5'd12, 5'd12);
        check("bypass_new1", rdata1, 32'h5555);
        check("bypass_new2", rdata2, 32'h5555);
        step();

        // 6. counter wrap
        mem(5'd13, 1'b1, 32'h13);
        step();
        mem(5'd0, 1'b0, 32'h0);
        force dut.write_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.write_cnt;
        #1;
        check("wrap_pre", wb_write_cnt, 32'hFFFF_FFFF);
        step();
        rd(5'd13, 5'd0);
        check("wrap_cnt", wb_write_cnt, 32'h0);
        check("wrap_reg13", rdata1, 32'h13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
